// File: rtl/riscv_lsu.sv
// Load-store unit: turns byte/half/word core requests into aligned memory transactions with a ready timeout.
// Optional build macro RISCV_LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses without touching memory.
module riscv_lsu #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic [1:0]  state_o
);
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wd_q, wd_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [2:0]    size_n;
    logic [3:0]    be_n;
    logic [31:0]   wd_n;
    logic          misalign;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    // Unsupported funct3 codes behave as a word access.
    always_comb begin
        case (core_size_i)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_n = core_size_i;
            default:                                size_n = 3'b010;
        endcase
    end

    always_comb begin
        be_n = 4'b1111;
        wd_n = core_wd_i;
        if (core_we_i) begin
            case (size_n[1:0])
                2'b00: begin
                    be_n = 4'b0001 << core_addr_i[1:0];
                    wd_n = {4{core_wd_i[7:0]}};
                end
                2'b01: begin
                    be_n = core_addr_i[1] ? 4'b1100 : 4'b0011;
                    wd_n = {2{core_wd_i[15:0]}};
                end
                default: begin
                    be_n = 4'b1111;
                    wd_n = core_wd_i;
                end
            endcase
        end
    end

`ifdef RISCV_LSU_MISALIGN_CHECK_EN
    assign misalign = ((size_n[1:0] == 2'b01) && core_addr_i[0]) ||
                      ((size_n[1:0] == 2'b10) && (core_addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = we_q;
        size_d  = size_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (core_req_i) begin
                    we_d   = core_we_i;
                    size_d = size_n;
                    off_d  = core_addr_i[1:0];
                    addr_d = {core_addr_i[31:2], 2'b00};
                    be_d   = be_n;
                    wd_d   = wd_n;
                    cnt_d  = '0;
                    if (misalign) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready on the final allowed cycle still counts as success.
                if (mem_ready_i) begin
                    if (!we_q) rdata_d = mem_rd_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LIMIT) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        case (off_q)
            2'b00:   byte_sel = rdata_q[7:0];
            2'b01:   byte_sel = rdata_q[15:8];
            2'b10:   byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            3'b000:  core_rd_o = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  core_rd_o = {{16{half_sel[15]}}, half_sel};
            3'b100:  core_rd_o = {24'd0, byte_sel};
            3'b101:  core_rd_o = {16'd0, half_sel};
            default: core_rd_o = rdata_q;
        endcase
    end

    assign mem_req_o    = (state_q == ST_ACCESS);
    assign mem_we_o     = we_q;
    assign mem_be_o     = be_q;
    assign mem_addr_o   = addr_q;
    assign mem_wd_o     = wd_q;
    assign core_stall_o = ((state_q == ST_IDLE) && core_req_i) || (state_q == ST_ACCESS);
    assign err_o        = (state_q == ST_RESP) && err_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: the bench plays core and memory, checking lanes, extension, latency and timeout.
module tb_riscv_lsu;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'b000;
    logic [31:0] core_addr_i = '0;
    logic [31:0] core_wd_i = '0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i = '0;
    logic        mem_ready_i = 1'b0;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    int          got_stalls, got_reqs;
    logic        got_we, got_err, done;
    logic [3:0]  got_be;
    logic [31:0] got_addr, got_wd, got_rd;

    riscv_lsu #(.TIMEOUT_CYCLES(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i), .state_o(state_o)
    );

    // clock/reset block
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the RESP cycle.
    task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata, input int waits);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        got_stalls = 0; got_reqs = 0; done = 1'b0;
        got_we = 1'b0; got_be = '0; got_addr = '0; got_wd = '0; got_rd = '0; got_err = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (core_stall_o) got_stalls++;
            if (mem_req_o) begin
                got_reqs++;
                got_we   = mem_we_o;
                got_be   = mem_be_o;
                got_addr = mem_addr_o;
                got_wd   = mem_wd_o;
                mem_ready_i = (got_reqs > waits);
                mem_rd_i    = rdata;
            end else begin
                mem_ready_i = 1'b0;
            end
            if (!core_stall_o) begin
                got_rd  = core_rd_o;
                got_err = err_o;
                done    = 1'b1;
            end
            @(negedge clk_i);
        end
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        check("access_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        core_req_i = 1'b1;
        #1;
        check("rst_stall_follows_req", {31'd0, core_stall_o}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wd", mem_wd_o, 32'd0);
        check("rst_core_rd", core_rd_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        core_req_i = 1'b0;
        #1;
        check("rst_stall_no_req", {31'd0, core_stall_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // SB at 0x103
        run_access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0);
        check("sb_addr", got_addr, 32'h0000_0100);
        check("sb_be", {28'd0, got_be}, 32'h8);
        check("sb_wd", got_wd, 32'hA5A5_A5A5);
        check("sb_we", {31'd0, got_we}, 32'd1);
        check("sb_stalls", got_stalls, 32'd2);
        check("sb_err", {31'd0, got_err}, 32'd0);

        // LB / LBU at 0x102, back-to-back
        run_access(1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h12F0_5634, 0);
        check("lb_rd", got_rd, 32'hFFFF_FFF0);
        check("lb_be", {28'd0, got_be}, 32'hF);
        check("lb_we", {31'd0, got_we}, 32'd0);
        run_access(1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h12F0_5634, 0);
        check("lbu_rd", got_rd, 32'h0000_00F0);

        // LH / LHU
        run_access(1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
        check("lh_rd", got_rd, 32'hFFFF_8001);
        check("lh_addr", got_addr, 32'h0000_0000);
        run_access(1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h8001_7FFF, 0);
        check("lhu_rd", got_rd, 32'h0000_7FFF);

        // SH upper half, SW, unknown size as word
        run_access(1'b1, 3'b001, 32'h0000_0206, 32'hCAFE_1234, 32'h0, 1);
        check("sh_be", {28'd0, got_be}, 32'hC);
        check("sh_wd", got_wd, 32'h1234_1234);
        check("sh_addr", got_addr, 32'h0000_0204);
        check("sh_stalls_1wait", got_stalls, 32'd3);
        run_access(1'b1, 3'b010, 32'h0000_0300, 32'h0123_4567, 32'h0, 0);
        check("sw_be", {28'd0, got_be}, 32'hF);
        check("sw_wd", got_wd, 32'h0123_4567);
        run_access(1'b0, 3'b011, 32'h0000_0008, 32'h0, 32'h8765_4321, 0);
        check("size011_rd", got_rd, 32'h8765_4321);

        // Timeout
        run_access(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h5555_5555, 100);
        check("to_access_cycles", got_reqs, 32'd15);
        check("to_stalls", got_stalls, 32'd16);
        check("to_err", {31'd0, got_err}, 32'd1);
        check("to_rd", got_rd, 32'd0);
        #1;
        check("to_back_idle", {30'd0, state_o}, 32'd0);
        check("to_err_cleared", {31'd0, err_o}, 32'd0);
        @(negedge clk_i);

        // Ready on the last allowed cycle
        run_access(1'b0, 3'b010, 32'h0000_0014, 32'h0, 32'h6666_7777, 14);
        check("edge_access_cycles", got_reqs, 32'd15);
        check("edge_err", {31'd0, got_err}, 32'd0);
        check("edge_rd", got_rd, 32'h6666_7777);

        // Reset during ACCESS of SW
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'b010;
        core_addr_i = 32'h0000_0400; core_wd_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        #1;
        check("rstmid_req_before", {31'd0, mem_req_o}, 32'd1);
        check("rstmid_wd", mem_wd_o, 32'hDEAD_BEEF);
        #1;
        rst_i = 1'b0;
        core_req_i = 1'b0;
        #1;
        check("rstmid_req_dropped", {31'd0, mem_req_o}, 32'd0);
        check("rstmid_state", {30'd0, state_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("rstmid_be", {28'd0, mem_be_o}, 32'd0);
        check("rstmid_addr", mem_addr_o, 32'd0);
        check("rstmid_wd_after", mem_wd_o, 32'd0);
        check("rstmid_we", {31'd0, mem_we_o}, 32'd0);
        check("rstmid_stall", {31'd0, core_stall_o}, 32'd0);
        @(negedge clk_i);

        // LW at 0x101
        run_access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hABCD_EF01, 0);
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
        check("mis_reqs", got_reqs, 32'd0);
        check("mis_stalls", got_stalls, 32'd1);
        check("mis_err", {31'd0, got_err}, 32'd1);
        check("mis_rd", got_rd, 32'd0);
`else
        check("mis_addr", got_addr, 32'h0000_0100);
        check("mis_stalls", got_stalls, 32'd2);
        check("mis_err", {31'd0, got_err}, 32'd0);
        check("mis_rd", got_rd, 32'hABCD_EF01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
